// File: rtl/vga_sync_gen_pkg.sv
// VGA sync generator: shared timing helpers and test-bar colour table.
// Used by vga_sync_gen and vga_timing_cnt.
package vga_sync_gen_pkg;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_rgb_t;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    localparam int NUM_BARS = 8;

    function automatic int blank_len(
        input int front,
        input int sync,
        input int back
    );
        return front + sync + back;
    endfunction

    function automatic int total_len(
        input int front,
        input int sync,
        input int back,
        input int act
    );
        return front + sync + back + act;
    endfunction

    function automatic int bar_width(input int act);
        return (act / NUM_BARS > 0) ? act / NUM_BARS : 1;
    endfunction

    function automatic bar_rgb_t bar_color(input logic [2:0] idx);
        bar_rgb_t c;
        unique case (bar_e'(idx))
            BAR_WHITE:   c = '{r: 1'b1, g: 1'b1, b: 1'b1};
            BAR_YELLOW:  c = '{r: 1'b1, g: 1'b1, b: 1'b0};
            BAR_CYAN:    c = '{r: 1'b0, g: 1'b1, b: 1'b1};
            BAR_GREEN:   c = '{r: 1'b0, g: 1'b1, b: 1'b0};
            BAR_MAGENTA: c = '{r: 1'b1, g: 1'b0, b: 1'b1};
            BAR_RED:     c = '{r: 1'b1, g: 1'b0, b: 1'b0};
            BAR_BLUE:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
            BAR_BLACK:   c = '{r: 1'b0, g: 1'b0, b: 1'b0};
            default:     c = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical position counters with wrap and line-end strobe.
// Both counters live in the pixel clock domain.
module vga_timing_cnt
    import vga_sync_gen_pkg::*;
#(
    parameter int H_W     = 11,
    parameter int V_W     = 11,
    parameter int H_TOTAL = 1040,
    parameter int V_TOTAL = 666
) (
    input  logic           clock,
    input  logic           aresetn,
    output logic [H_W-1:0] hpos,
    output logic [V_W-1:0] vpos,
    output logic           line_end
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    assign line_end = (hpos == H_LAST);

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            hpos <= '0;
            vpos <= '0;
        end else if (line_end) begin
            hpos <= '0;
            if (vpos == V_LAST) begin
                vpos <= '0;
            end else begin
                vpos <= vpos + V_W'(1);
            end
        end else begin
            hpos <= hpos + H_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/blank generator with lead-time pixel request and RGB pipeline.
// Define VGA_SYNC_GEN_TESTPAT_EN to add pattern_sel and the colour-bar source.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   H_TOTAL_WIDTH = 11,
    parameter int   V_TOTAL_WIDTH = 11,
    parameter int   COLOR_IN_W    = 10,
    parameter int   COLOR_OUT_W   = 8,
    parameter logic POLARITY      = 1'b1,
    parameter int   H_FRONT       = 56,
    parameter int   H_SYNC        = 120,
    parameter int   H_BACK        = 64,
    parameter int   H_ACT         = 800,
    parameter int   V_FRONT       = 37,
    parameter int   V_SYNC        = 6,
    parameter int   V_BACK        = 23,
    parameter int   V_ACT         = 600,
    parameter int   REQ_LEAD      = 1
) (
    input  logic                     clock,
    input  logic                     aresetn,
`ifdef VGA_SYNC_GEN_TESTPAT_EN
    input  logic                     pattern_sel,
`endif
    input  logic [COLOR_IN_W-1:0]    R_in,
    input  logic [COLOR_IN_W-1:0]    G_in,
    input  logic [COLOR_IN_W-1:0]    B_in,
    output logic                     req,
    output logic [H_TOTAL_WIDTH-1:0] req_x,
    output logic [V_TOTAL_WIDTH-1:0] req_y,
    output logic [COLOR_OUT_W-1:0]   R_out,
    output logic [COLOR_OUT_W-1:0]   G_out,
    output logic [COLOR_OUT_W-1:0]   B_out,
    output logic                     h_sync,
    output logic                     v_sync,
    output logic                     blank_n,
    output logic                     sync_n,
    output logic                     vga_clk,
    output logic                     frame_start,
    output logic                     line_start
);

    localparam int HW = H_TOTAL_WIDTH;
    localparam int VW = V_TOTAL_WIDTH;
    localparam int CW = COLOR_OUT_W;

    localparam int H_BLANK = blank_len(H_FRONT, H_SYNC, H_BACK);
    localparam int H_TOTAL = total_len(H_FRONT, H_SYNC, H_BACK, H_ACT);
    localparam int V_BLANK = blank_len(V_FRONT, V_SYNC, V_BACK);
    localparam int V_TOTAL = total_len(V_FRONT, V_SYNC, V_BACK, V_ACT);

    localparam logic [HW-1:0] H_BLANK_P = HW'(H_BLANK);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_FRONT);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_BLANK_P = VW'(V_BLANK);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_FRONT);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_FRONT + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW:0]   H_TOTAL_E = (HW + 1)'(H_TOTAL);
    localparam logic [HW:0]   LEAD_E    = (HW + 1)'(REQ_LEAD);

    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          line_end;

    vga_timing_cnt #(
        .H_W     (HW),
        .V_W     (VW),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .clock    (clock),
        .aresetn  (aresetn),
        .hpos     (hpos),
        .vpos     (vpos),
        .line_end (line_end)
    );

    // Request position runs REQ_LEAD pixels ahead, wrapping into the next line/frame
    logic [HW:0]   lead_sum;
    logic          lead_wrap;
    logic [HW-1:0] lead_h;
    logic [VW-1:0] lead_v;

    assign lead_sum  = {1'b0, hpos} + LEAD_E;
    assign lead_wrap = (lead_sum >= H_TOTAL_E);
    assign lead_h    = lead_wrap ? HW'(lead_sum - H_TOTAL_E)
                                 : HW'(lead_sum);

    always_comb begin
        lead_v = vpos;
        if (lead_wrap) begin
            lead_v = (vpos == V_LAST) ? '0 : vpos + VW'(1);
        end
    end

    assign req   = (lead_h >= H_BLANK_P) && (lead_v >= V_BLANK_P);
    assign req_x = req ? lead_h - H_BLANK_P : '0;
    assign req_y = req ? lead_v - V_BLANK_P : '0;

    logic cur_act;
    logic cur_hs;
    logic cur_vs;
    logic cur_first_x;

    assign cur_act     = (hpos >= H_BLANK_P) && (vpos >= V_BLANK_P);
    assign cur_hs      = (hpos >= H_SYNC_LO) && (hpos <= H_SYNC_HI);
    assign cur_vs      = (vpos >= V_SYNC_LO) && (vpos <= V_SYNC_HI);
    assign cur_first_x = (hpos == H_BLANK_P);

    logic [CW-1:0] r_conv;
    logic [CW-1:0] g_conv;
    logic [CW-1:0] b_conv;

    if (COLOR_IN_W >= COLOR_OUT_W) begin : g_trunc
        localparam int SH = COLOR_IN_W - COLOR_OUT_W;
        assign r_conv = CW'(R_in >> SH);
        assign g_conv = CW'(G_in >> SH);
        assign b_conv = CW'(B_in >> SH);
    end else begin : g_pad
        localparam int SH = COLOR_OUT_W - COLOR_IN_W;
        assign r_conv = CW'(R_in) << SH;
        assign g_conv = CW'(G_in) << SH;
        assign b_conv = CW'(B_in) << SH;
    end

    logic [CW-1:0] pix_r;
    logic [CW-1:0] pix_g;
    logic [CW-1:0] pix_b;

`ifdef VGA_SYNC_GEN_TESTPAT_EN
    localparam int BAR_W = bar_width(H_ACT);

    logic [HW-1:0] act_x;
    logic [HW-1:0] bar_raw;
    logic [2:0]    bar_idx;
    bar_rgb_t      bar;

    // Any remainder pixels past the eighth bar stay black
    assign act_x   = hpos - H_BLANK_P;
    assign bar_raw = act_x / HW'(BAR_W);
    assign bar_idx = (bar_raw > HW'(7)) ? 3'd7 : bar_raw[2:0];
    assign bar     = bar_color(bar_idx);

    assign pix_r = pattern_sel ? {CW{bar.r}} : r_conv;
    assign pix_g = pattern_sel ? {CW{bar.g}} : g_conv;
    assign pix_b = pattern_sel ? {CW{bar.b}} : b_conv;
`else
    assign pix_r = r_conv;
    assign pix_g = g_conv;
    assign pix_b = b_conv;
`endif

    logic hs_q;
    logic vs_q;

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            R_out       <= '0;
            G_out       <= '0;
            B_out       <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            R_out       <= cur_act ? pix_r : '0;
            G_out       <= cur_act ? pix_g : '0;
            B_out       <= cur_act ? pix_b : '0;
            hs_q        <= cur_hs;
            vs_q        <= cur_vs;
            blank_n     <= cur_act;
            frame_start <= cur_act && cur_first_x && (vpos == V_BLANK_P);
            line_start  <= cur_act && cur_first_x;
        end
    end

    // Polarity is a wiring choice on the registered raw sync
    assign h_sync  = POLARITY ? hs_q : ~hs_q;
    assign v_sync  = POLARITY ? vs_q : ~vs_q;
    assign sync_n  = 1'b1;
    assign vga_clk = ~clock;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen on a 14x8 toy timing.
// Honors VGA_SYNC_GEN_TESTPAT_EN for the colour-bar path.
module tb_vga_sync_gen;

    localparam int HT  = 14;
    localparam int VT  = 8;
    localparam int HBL = 6;
    localparam int VBL = 4;
    localparam int FRAME = HT * VT;
    // first active pixel at linear position VBL*HT+HBL, seen one cycle later
    localparam int FS_CYC = VBL * HT + HBL + 1;

    logic clock = 1'b0;
    logic aresetn = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    always_ff @(posedge clock) begin
        if (!aresetn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // main instance: lead 2, 8-bit passthrough, R_in echoes req_x
    logic [7:0]  a_r, a_g, a_b, a_ro, a_go, a_bo;
    logic        a_req, a_hs, a_vs, a_bn, a_sn, a_vc, a_fs, a_ls;
    logic [10:0] a_rx, a_ry, rd1, rd2;

    always_ff @(posedge clock) begin
        rd1 <= a_rx;
        rd2 <= rd1;
    end
    assign a_r = rd2[7:0];
    assign a_g = 8'h00;
    assign a_b = 8'h5A;

    vga_sync_gen #(
        .COLOR_IN_W(8), .COLOR_OUT_W(8), .POLARITY(1'b1),
        .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .REQ_LEAD(2)
    ) dut (
        .clock(clock), .aresetn(aresetn),
`ifdef VGA_SYNC_GEN_TESTPAT_EN
        .pattern_sel(1'b0),
`endif
        .R_in(a_r), .G_in(a_g), .B_in(a_b),
        .req(a_req), .req_x(a_rx), .req_y(a_ry),
        .R_out(a_ro), .G_out(a_go), .B_out(a_bo),
        .h_sync(a_hs), .v_sync(a_vs), .blank_n(a_bn),
        .sync_n(a_sn), .vga_clk(a_vc),
        .frame_start(a_fs), .line_start(a_ls)
    );

    // active-low syncs, 10 -> 12 bit zero pad
    logic [9:0]  p_r, p_g, p_b;
    logic [11:0] p_ro, p_go, p_bo;
    logic        p_req, p_hs, p_vs, p_bn, p_sn, p_vc, p_fs, p_ls;
    logic [10:0] p_rx, p_ry;
    assign p_r = 10'h3FF;
    assign p_g = 10'h001;
    assign p_b = 10'h000;

    vga_sync_gen #(
        .COLOR_IN_W(10), .COLOR_OUT_W(12), .POLARITY(1'b0),
        .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .REQ_LEAD(1)
    ) dut_p (
        .clock(clock), .aresetn(aresetn),
`ifdef VGA_SYNC_GEN_TESTPAT_EN
        .pattern_sel(1'b0),
`endif
        .R_in(p_r), .G_in(p_g), .B_in(p_b),
        .req(p_req), .req_x(p_rx), .req_y(p_ry),
        .R_out(p_ro), .G_out(p_go), .B_out(p_bo),
        .h_sync(p_hs), .v_sync(p_vs), .blank_n(p_bn),
        .sync_n(p_sn), .vga_clk(p_vc),
        .frame_start(p_fs), .line_start(p_ls)
    );

    // 10 -> 8 bit truncation, lead 0, colour bars when enabled
    logic [9:0]  m_r, m_g, m_b;
    logic [7:0]  m_ro, m_go, m_bo;
    logic        m_req, m_hs, m_vs, m_bn, m_sn, m_vc, m_fs, m_ls;
    logic [10:0] m_rx, m_ry;
    assign m_r = 10'h2C5;
    assign m_g = 10'h0FF;
    assign m_b = 10'h000;

    vga_sync_gen #(
        .COLOR_IN_W(10), .COLOR_OUT_W(8), .POLARITY(1'b1),
        .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .REQ_LEAD(0)
    ) dut_m (
        .clock(clock), .aresetn(aresetn),
`ifdef VGA_SYNC_GEN_TESTPAT_EN
        .pattern_sel(1'b1),
`endif
        .R_in(m_r), .G_in(m_g), .B_in(m_b),
        .req(m_req), .req_x(m_rx), .req_y(m_ry),
        .R_out(m_ro), .G_out(m_go), .B_out(m_bo),
        .h_sync(m_hs), .v_sync(m_vs), .blank_n(m_bn),
        .sync_n(m_sn), .vga_clk(m_vc),
        .frame_start(m_fs), .line_start(m_ls)
    );

    // bar colours r,g,b: white yellow cyan green magenta red blue black
    logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                             3'b101, 3'b100, 3'b001, 3'b000};

    int p, h, v, q, rh, rv, bi;
    logic act, hs, vs, fs, ls, rq, rq0;
    logic [7:0] m_exp_r, m_exp_g;

    always @(negedge clock) begin
        if (mon_en) begin
            // outputs at cycle cyc describe position cyc-1
            p   = cyc - 1;
            h   = (cyc == 0) ? 0 : p % HT;
            v   = (cyc == 0) ? 0 : (p / HT) % VT;
            act = (cyc != 0) && h >= HBL && v >= VBL;
            hs  = (cyc != 0) && h >= 2 && h <= 4;
            vs  = (cyc != 0) && v >= 1 && v <= 2;
            fs  = act && h == HBL && v == VBL;
            ls  = act && h == HBL;
            q   = cyc + 2;
            rh  = q % HT;
            rv  = (q / HT) % VT;
            rq  = rh >= HBL && rv >= VBL;
            rq0 = (cyc % HT) >= HBL && ((cyc / HT) % VT) >= VBL;
            check("h_sync", a_hs, hs);
            check("v_sync", a_vs, vs);
            check("blank_n", a_bn, act);
            check("frame_start", a_fs, fs);
            check("line_start", a_ls, ls);
            check("req", a_req, rq);
            check("req_x", a_rx, rq ? rh - HBL : 0);
            check("req_y", a_ry, rq ? rv - VBL : 0);
            check("R_out", a_ro, act ? h - HBL : 0);
            check("B_out", a_bo, act ? 8'h5A : 8'h00);
            check("p_h_sync", p_hs, !hs);
            check("p_v_sync", p_vs, !vs);
            check("p_R_out", p_ro, act ? 12'hFFC : 12'h000);
            check("p_G_out", p_go, act ? 12'h004 : 12'h000);
            check("m_req", m_req, rq0);
`ifdef VGA_SYNC_GEN_TESTPAT_EN
            bi = act ? h - HBL : 0;
            m_exp_r = (act && bars[bi][2]) ? 8'hFF : 8'h00;
            m_exp_g = (act && bars[bi][1]) ? 8'hFF : 8'h00;
`else
            m_exp_r = act ? 8'hB1 : 8'h00;
            m_exp_g = act ? 8'h3F : 8'h00;
`endif
            check("m_R_out", m_ro, m_exp_r);
            check("m_G_out", m_go, m_exp_g);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_h_sync"}, a_hs, 1'b0);
        check({tag, "_v_sync"}, a_vs, 1'b0);
        check({tag, "_p_h_sync"}, p_hs, 1'b1);
        check({tag, "_p_v_sync"}, p_vs, 1'b1);
        check({tag, "_blank_n"}, a_bn, 1'b0);
        check({tag, "_R_out"}, a_ro, 8'h00);
        check({tag, "_req"}, a_req, 1'b0);
        check({tag, "_frame_start"}, a_fs, 1'b0);
        check({tag, "_line_start"}, a_ls, 1'b0);
    endtask

    int fs_cyc [$];
    int hs_rise [$];
    logic hs_prev;
    logic found;

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("rst");
        check("sync_n", a_sn, 1'b1);
        check("vga_clk", a_vc, 1'b1);
        mon_en  = 1'b1;
        aresetn = 1'b1;
        hs_prev = 1'b0;

        repeat (2 * FRAME) begin
            @(negedge clock);
            if (a_fs) fs_cyc.push_back(cyc);
            if (a_hs && !hs_prev) hs_rise.push_back(cyc);
            hs_prev = a_hs;
        end
        check("fs_count", fs_cyc.size(), 2);
        if (fs_cyc.size() >= 2) begin
            check("fs_first", fs_cyc[0], FS_CYC);
            check("fs_period", fs_cyc[1] - fs_cyc[0], FRAME);
        end
        check("hs_first", (hs_rise.size() > 0) ? hs_rise[0] : -1, 3);
        check("hs_period", (hs_rise.size() > 1) ? hs_rise[1] - hs_rise[0] : -1, HT);

        // land on hpos=5, vpos=3 and pulse reset for one edge
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clock);
            if (cyc % FRAME == 3 * HT + 5) found = 1'b1;
        end
        check("mid_seek", found, 1'b1);
        aresetn = 1'b0;
        @(negedge clock);
        check_reset_vals("mid");
        aresetn = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clock);
            if (a_fs) found = 1'b1;
        end
        check("mid_fs_seen", found, 1'b1);
        check("mid_fs_cyc", cyc, FS_CYC);

        repeat (HT * 3) @(negedge clock);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
